// File: rtl/mux2_rr_arbiter_if.sv
// Shared-channel bundle for the two-requester round-robin arbiter.
// master: the producer/consumer side (drives requests, data, ready).
// slave : the arbiter side (drives acks, shared data/valid, select, busy).
interface mux2_rr_arbiter_if #(
    parameter int DW = 2
);
    logic          x_req;
    logic [DW-1:0] x_data;
    logic          x_ack;
    logic          y_req;
    logic [DW-1:0] y_data;
    logic          y_ack;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          s;
    logic          busy;

    modport master (
        output x_req, x_data, y_req, y_data, m_ready,
        input  x_ack, y_ack, m_data, m_valid, s, busy
    );

    modport slave (
        input  x_req, x_data, y_req, y_data, m_ready,
        output x_ack, y_ack, m_data, m_valid, s, busy
    );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one DW-bit valid/ready channel between
// requesters X and Y. Drives the 2:1 data mux select and the handshake,
// capping each ownership period at MAX_BEATS transfers while the other
// side waits. Ownership changes only on a transfer or when the owner
// drops its request, so a beat is never preempted.
module mux2_rr_arbiter #(
    parameter int DW        = 2,
    parameter int MAX_BEATS = 4
) (
    input logic              clk,
    input logic              rst_n,
    mux2_rr_arbiter_if.slave bus
);

    localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BEATS - 1);

    // A zero-beat quota would never let the owner transfer anything.
    if (MAX_BEATS < 1) begin : g_bad_param
        $error("mux2_rr_arbiter: MAX_BEATS must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_X = 2'd1,
        OWN_Y = 2'd2
    } state_t;

    // last_q: 0 = X owned last, 1 = Y owned last
    state_t        state_q, state_nx;
    logic          s_q, s_nx;
    logic          last_q, last_nx;
    logic [CW-1:0] cnt_q, cnt_nx;

    logic          mv, xa, ya;

    // State register; reset leaves Y as last owner so X wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nx;
            s_q     <= s_nx;
            last_q  <= last_nx;
            cnt_q   <= cnt_nx;
        end
    end

    // Next-state and handshake outputs; stalls (owner req high, ready low)
    // fall through the defaults and hold everything.
    always_comb begin
        state_nx = state_q;
        s_nx     = s_q;
        last_nx  = last_q;
        cnt_nx   = cnt_q;
        mv       = 1'b0;
        xa       = 1'b0;
        ya       = 1'b0;

        case (state_q)
            IDLE: begin
                // Tie goes to whichever side did not own last.
                if (bus.x_req && (!bus.y_req || last_q)) begin
                    state_nx = OWN_X;
                    s_nx     = 1'b0;
                    cnt_nx   = '0;
                end else if (bus.y_req) begin
                    state_nx = OWN_Y;
                    s_nx     = 1'b1;
                    cnt_nx   = '0;
                end
            end

            OWN_X: begin
                mv = bus.x_req;
                xa = bus.x_req & bus.m_ready;
                if (!bus.x_req) begin
                    // Owner done or aborted: hand over directly or go idle.
                    last_nx = 1'b0;
                    cnt_nx  = '0;
                    if (bus.y_req) begin
                        state_nx = OWN_Y;
                        s_nx     = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (bus.m_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        // Quota used up: yield if Y waits, else start a fresh quota.
                        cnt_nx = '0;
                        if (bus.y_req) begin
                            state_nx = OWN_Y;
                            s_nx     = 1'b1;
                            last_nx  = 1'b0;
                        end
                    end else begin
                        cnt_nx = cnt_q + CW'(1);
                    end
                end
            end

            OWN_Y: begin
                mv = bus.y_req;
                ya = bus.y_req & bus.m_ready;
                if (!bus.y_req) begin
                    last_nx = 1'b1;
                    cnt_nx  = '0;
                    if (bus.x_req) begin
                        state_nx = OWN_X;
                        s_nx     = 1'b0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else if (bus.m_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_nx = '0;
                        if (bus.x_req) begin
                            state_nx = OWN_X;
                            s_nx     = 1'b0;
                            last_nx  = 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt_q + CW'(1);
                    end
                end
            end

            default: begin
                state_nx = IDLE;
                s_nx     = 1'b0;
                cnt_nx   = '0;
            end
        endcase
    end

    assign bus.m_valid = mv;
    assign bus.x_ack   = xa;
    assign bus.y_ack   = ya;
    assign bus.s       = s_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.m_data  = s_q ? bus.y_data : bus.x_data;

endmodule
